// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the chunked, pipelined add/subtract unit: geometry
// derivation and the small control record carried with each operation.
package adder_pkg;

  // Control bits of one offered operation; operand widths live in the top.
  typedef struct packed {
    logic sub;
    logic cin;
  } op_ctrl_t;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Valid geometry: at least one stage, no more stages than bits, equal chunks.
  function automatic bit geometry_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// One pipeline slice: adds one CHUNK-wide slice of the operands with the
// incoming carry and holds the partial result in a valid/ready register.
module adder_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_sum,
  input  logic             up_carry,
  input  logic [WIDTH-1:0] up_lhs,
  input  logic [WIDTH-1:0] up_rhs,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_sum,
  output logic             dn_carry,
  output logic [WIDTH-1:0] dn_lhs,
  output logic [WIDTH-1:0] dn_rhs
);

  localparam int LSB = IDX * CHUNK;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] lhs_rem;
    logic [WIDTH-1:0] rhs_rem;
  } payload_t;

  logic           valid_q;
  payload_t       data_q;
  payload_t       data_d;
  logic [CHUNK:0] chunk_sum;
  logic           load;

  // Handshake: a transfer happens on an edge where valid && ready are both
  // high; ready never depends on valid, and a held slot keeps its payload
  // unchanged until the downstream side takes it.
  assign up_ready = !valid_q || dn_ready;
  assign load     = up_valid && up_ready;

  assign chunk_sum = {1'b0, up_lhs[LSB +: CHUNK]}
                   + {1'b0, up_rhs[LSB +: CHUNK]}
                   + {{CHUNK{1'b0}}, up_carry};

  always_comb begin
    data_d                  = '0;
    data_d.sum              = up_sum;
    data_d.sum[LSB +: CHUNK] = chunk_sum[CHUNK-1:0];
    data_d.carry            = chunk_sum[CHUNK];
    data_d.lhs_rem          = up_lhs;
    data_d.rhs_rem          = up_rhs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= data_d;
    end else if (dn_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign dn_valid = valid_q;
  assign dn_sum   = data_q.sum;
  assign dn_carry = data_q.carry;
  assign dn_lhs   = data_q.lhs_rem;
  assign dn_rhs   = data_q.rhs_rem;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: operands are split into STAGES chunks and the
// carry ripples one chunk per cycle through a chain of adder_stage slices.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_enq_valid,
  output logic             io_enq_ready,
  input  logic             io_enq_sub,
  input  logic             io_enq_cin,
  input  logic [WIDTH-1:0] io_enq_lhs,
  input  logic [WIDTH-1:0] io_enq_rhs,
  output logic             io_deq_valid,
  input  logic             io_deq_ready,
  output logic [WIDTH-1:0] io_deq_out,
  output logic             io_deq_cout
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $fatal(1, "pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  op_ctrl_t         ctrl;
  logic [WIDTH-1:0] rhs_eff;
  logic             c0;

  // Subtraction is lhs + ~rhs + ~borrow, so sub flips both rhs and carry-in.
  assign ctrl    = '{sub: io_enq_sub, cin: io_enq_cin};
  assign rhs_eff = io_enq_rhs ^ {WIDTH{ctrl.sub}};
  assign c0      = ctrl.cin ^ ctrl.sub;

  // Index k is the input side of stage k; index STAGES is the output side.
  logic             v_p     [STAGES+1];
  logic             rdy_p   [STAGES+1];
  logic [WIDTH-1:0] sum_p   [STAGES+1];
  logic             carry_p [STAGES+1];
  logic [WIDTH-1:0] lhs_p   [STAGES+1];
  logic [WIDTH-1:0] rhs_p   [STAGES+1];

  assign v_p[0]         = io_enq_valid;
  assign sum_p[0]       = '0;
  assign carry_p[0]     = c0;
  assign lhs_p[0]       = io_enq_lhs;
  assign rhs_p[0]       = rhs_eff;
  assign rdy_p[STAGES]  = io_deq_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (reset),
      .up_valid (v_p[k]),
      .up_ready (rdy_p[k]),
      .up_sum   (sum_p[k]),
      .up_carry (carry_p[k]),
      .up_lhs   (lhs_p[k]),
      .up_rhs   (rhs_p[k]),
      .dn_valid (v_p[k+1]),
      .dn_ready (rdy_p[k+1]),
      .dn_sum   (sum_p[k+1]),
      .dn_carry (carry_p[k+1]),
      .dn_lhs   (lhs_p[k+1]),
      .dn_rhs   (rhs_p[k+1])
    );
  end

  assign io_enq_ready = rdy_p[0];
  assign io_deq_valid = v_p[STAGES];
  assign io_deq_out   = sum_p[STAGES];
  assign io_deq_cout  = carry_p[STAGES];

  // Operand remainders leaving the last stage have no consumer.
  logic unused_tail;
  assign unused_tail = ^{lhs_p[STAGES], rhs_p[STAGES]};

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: an 8-bit/4-stage instance and a 16-bit/1-stage
// instance, directed vectors with hand-computed results and queue scoreboards.
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  // ---------------- instance A: WIDTH=8, STAGES=4 ----------------
  logic       a_enq_valid, a_enq_ready, a_enq_sub, a_enq_cin;
  logic [7:0] a_enq_lhs, a_enq_rhs;
  logic       a_deq_valid, a_deq_ready, a_deq_cout;
  logic [7:0] a_deq_out;

  pipelined_adder #(.WIDTH(8), .STAGES(4)) u_dut_a (
    .clk          (clk),
    .reset        (reset),
    .io_enq_valid (a_enq_valid),
    .io_enq_ready (a_enq_ready),
    .io_enq_sub   (a_enq_sub),
    .io_enq_cin   (a_enq_cin),
    .io_enq_lhs   (a_enq_lhs),
    .io_enq_rhs   (a_enq_rhs),
    .io_deq_valid (a_deq_valid),
    .io_deq_ready (a_deq_ready),
    .io_deq_out   (a_deq_out),
    .io_deq_cout  (a_deq_cout)
  );

  // ---------------- instance B: WIDTH=16, STAGES=1 ----------------
  logic        b_enq_valid, b_enq_ready, b_enq_sub, b_enq_cin;
  logic [15:0] b_enq_lhs, b_enq_rhs;
  logic        b_deq_valid, b_deq_ready, b_deq_cout;
  logic [15:0] b_deq_out;

  pipelined_adder #(.WIDTH(16), .STAGES(1)) u_dut_b (
    .clk          (clk),
    .reset        (reset),
    .io_enq_valid (b_enq_valid),
    .io_enq_ready (b_enq_ready),
    .io_enq_sub   (b_enq_sub),
    .io_enq_cin   (b_enq_cin),
    .io_enq_lhs   (b_enq_lhs),
    .io_enq_rhs   (b_enq_rhs),
    .io_deq_valid (b_deq_valid),
    .io_deq_ready (b_deq_ready),
    .io_deq_out   (b_deq_out),
    .io_deq_cout  (b_deq_cout)
  );

  // ---------------- scoreboard ----------------
  logic [8:0]  exp_a[$];   // {cout, out}
  logic [16:0] exp_b[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitors: pop on a handshake, compare against queue head while stalled.
  always @(negedge clk) begin
    if (reset && a_deq_valid) begin
      if (exp_a.size() == 0) check("a_spurious_result", {a_deq_cout, a_deq_out}, 32'hdead);
      else if (a_deq_ready) check("a_result", {a_deq_cout, a_deq_out}, exp_a.pop_front());
      else check("a_stall_hold", {a_deq_cout, a_deq_out}, exp_a[0]);
    end
  end

  always @(negedge clk) begin
    if (reset && b_deq_valid) begin
      if (exp_b.size() == 0) check("b_spurious_result", {b_deq_cout, b_deq_out}, 32'hdead);
      else if (b_deq_ready) check("b_result", {b_deq_cout, b_deq_out}, exp_b.pop_front());
      else check("b_stall_hold", {b_deq_cout, b_deq_out}, exp_b[0]);
    end
  end

  // ---------------- drivers ----------------
  task automatic send_a(input logic sub, input logic cin, input logic [7:0] lhs,
                        input logic [7:0] rhs, input logic [8:0] exp);
    bit got = 0;
    int guard = 0;
    a_enq_valid = 1'b1;
    a_enq_sub = sub; a_enq_cin = cin; a_enq_lhs = lhs; a_enq_rhs = rhs;
    while (!got && guard < 100) begin
      @(negedge clk);
      got = a_enq_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (got) exp_a.push_back(exp);
    else check("a_accept_timeout", 32'd0, 32'd1);
    a_enq_valid = 1'b0;
  endtask

  task automatic send_b(input logic sub, input logic cin, input logic [15:0] lhs,
                        input logic [15:0] rhs, input logic [16:0] exp);
    bit got = 0;
    int guard = 0;
    b_enq_valid = 1'b1;
    b_enq_sub = sub; b_enq_cin = cin; b_enq_lhs = lhs; b_enq_rhs = rhs;
    while (!got && guard < 100) begin
      @(negedge clk);
      got = b_enq_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (got) exp_b.push_back(exp);
    else check("b_accept_timeout", 32'd0, 32'd1);
    b_enq_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_a_left", exp_a.size(), 0);
    check("drain_b_left", exp_b.size(), 0);
  endtask

  // Back-to-back table: {sub, cin, lhs, rhs} -> {cout, out}, worked by hand.
  logic       t_sub [16] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 1, 0};
  logic       t_cin [16] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0};
  logic [7:0] t_lhs [16] = '{8'h12, 8'h80, 8'hFF, 8'h0F, 8'hAA, 8'hAA, 8'h10, 8'h00,
                             8'h80, 8'h10, 8'h00, 8'h7F, 8'hC3, 8'hFF, 8'h3C, 8'h99};
  logic [7:0] t_rhs [16] = '{8'h34, 8'h80, 8'h00, 8'h01, 8'h55, 8'h55, 8'h01, 8'h01,
                             8'h80, 8'h01, 8'h00, 8'h01, 8'h3C, 8'hFF, 8'hC3, 8'h77};
  logic [8:0] t_exp [16] = '{9'h046, 9'h100, 9'h100, 9'h010, 9'h0FF, 9'h100, 9'h10F, 9'h0FF,
                             9'h100, 9'h10E, 9'h0FF, 9'h080, 9'h100, 9'h100, 9'h079, 9'h110};

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    a_enq_valid = 0; a_enq_sub = 0; a_enq_cin = 0; a_enq_lhs = '0; a_enq_rhs = '0;
    b_enq_valid = 0; b_enq_sub = 0; b_enq_cin = 0; b_enq_lhs = '0; b_enq_rhs = '0;
    a_deq_ready = 1'b1;
    b_deq_ready = 1'b1;
    #1;
    check("rst_a_deq_valid", a_deq_valid, 0);
    check("rst_a_deq_out", {a_deq_cout, a_deq_out}, 0);
    check("rst_b_deq_valid", b_deq_valid, 0);
    check("rst_b_deq_out", {b_deq_cout, b_deq_out}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_a_enq_ready", a_enq_ready, 1);
    check("rst_b_enq_ready", b_enq_ready, 1);

    // Carry ripples through all four chunks; result lands 4 edges after accept.
    send_a(0, 0, 8'hFF, 8'h01, 9'h100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("a_latency_valid", a_deq_valid, (i == 3) ? 1 : 0);
    end
    @(posedge clk); #1;

    // Subtraction with and without borrow.
    send_a(1, 0, 8'h05, 8'h07, 9'h0FE);
    send_a(1, 0, 8'h07, 8'h05, 9'h102);
    wait_drain();

    // Sixteen back-to-back operations.
    for (int i = 0; i < 16; i++) send_a(t_sub[i], t_cin[i], t_lhs[i], t_rhs[i], t_exp[i]);
    wait_drain();

    // Backpressure: four fill the pipe, the fifth is refused until release.
    a_deq_ready = 1'b0;
    send_a(0, 0, 8'h01, 8'h02, 9'h003);
    send_a(0, 0, 8'hF0, 8'h20, 9'h110);
    send_a(1, 0, 8'h09, 8'h03, 9'h106);
    send_a(1, 0, 8'h03, 8'h09, 9'h0FA);
    a_enq_valid = 1'b1;
    a_enq_sub = 0; a_enq_cin = 1; a_enq_lhs = 8'h40; a_enq_rhs = 8'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("a_full_enq_ready", a_enq_ready, 0);
      @(posedge clk); #1;
    end
    check("a_full_count", exp_a.size(), 4);
    a_deq_ready = 1'b1;
    send_a(0, 1, 8'h40, 8'h40, 9'h081);
    wait_drain();

    // Reset with three operations in flight.
    a_deq_ready = 1'b0;
    send_a(0, 0, 8'h11, 8'h22, 9'h033);
    send_a(0, 0, 8'h44, 8'h55, 9'h099);
    send_a(0, 0, 8'h66, 8'h77, 9'h0DD);
    repeat (2) begin @(posedge clk); #1; end
    check("a_stalled_valid", a_deq_valid, 1);
    reset = 1'b0;
    exp_a.delete();
    exp_b.delete();
    #1;
    check("a_reset_deq_valid", a_deq_valid, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("a_post_reset_enq_ready", a_enq_ready, 1);
    a_deq_ready = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    send_a(0, 0, 8'h01, 8'h01, 9'h002);
    wait_drain();

    // Single-stage 16-bit instance: latency one edge.
    send_b(0, 1, 16'h8000, 16'h8000, 17'h10001);
    @(negedge clk);
    check("b_latency_valid", b_deq_valid, 1);
    @(posedge clk); #1;
    send_b(1, 0, 16'h1234, 16'h0234, 17'h11000);
    send_b(0, 1, 16'hFFFF, 16'hFFFF, 17'h1FFFF);
    send_b(1, 0, 16'h0000, 16'h0001, 17'h0FFFF);
    send_b(0, 0, 16'h1234, 16'h4321, 17'h05555);
    send_b(1, 1, 16'h5555, 16'h5555, 17'h0FFFF);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
